// File: rtl/video_stream_rx.sv
// Receiver for the fv/lv/8-bit byte stream: packs R,G,B bytes into tagged 24-bit pixels,
// measures line width and frame height, and keeps sticky framing-error flags.
module video_stream_rx #(
    parameter int BYTES_PER_LINE  = 1920,
    parameter int LINES_PER_FRAME = 1080,
    parameter int LV_DELAY        = 1
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic        fv,
    input  logic        lv,
    input  logic [7:0]  data,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [23:0] pix_rgb,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        sof,
    output logic        eol,
    output logic        frame_done,
    output logic [11:0] line_bytes,
    output logic [11:0] frame_lines,
    output logic        err_partial,
    output logic        err_width,
    output logic        err_height
);

    localparam logic [11:0] BPL_W = 12'(BYTES_PER_LINE);
    localparam logic [11:0] LPF_W = 12'(LINES_PER_FRAME);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2,
        LINE  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        fv_a;
    logic        lv_a;

    logic        frame_start;
    logic        line_start;
    logic        capture;
    logic        end_line;
    logic        end_frame;

    logic [1:0]  phase;
    logic [11:0] byte_cnt;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic [11:0] line_cnt;
    logic [7:0]  r_byte;
    logic [7:0]  g_byte;

    logic [1:0]  eff_phase;
    logic [11:0] eff_count;
    logic [11:0] lines_final;

    logic        set_partial;
    logic        set_width;
    logic        set_height;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    generate
        if (LV_DELAY == 0) begin : g_align_none
            assign fv_a = fv;
            assign lv_a = lv;
        end else begin : g_align_reg
            always_ff @(posedge pixclk or posedge rst) begin
                if (rst) begin
                    fv_a <= 1'b0;
                    lv_a <= 1'b0;
                end else begin
                    fv_a <= fv;
                    lv_a <= lv;
                end
            end
        end
    endgenerate

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // SYNC also looks at raw fv: the delay register reads 0 straight after reset,
    // which would otherwise fake a frame gap while a frame is still running.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        line_start  = 1'b0;
        capture     = 1'b0;
        end_line    = 1'b0;
        end_frame   = 1'b0;
        case (state)
            SYNC: begin
                if (!fv_a && !fv) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (fv_a) begin
                    next_state  = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                if (!fv_a) begin
                    next_state = IDLE;
                    end_frame  = 1'b1;
                end else if (lv_a) begin
                    next_state = LINE;
                    line_start = 1'b1;
                    capture    = 1'b1;
                end
            end
            LINE: begin
                if (!fv_a) begin
                    next_state = IDLE;
                    end_line   = 1'b1;
                    end_frame  = 1'b1;
                end else if (!lv_a) begin
                    next_state = FRAME;
                    end_line   = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            default: begin
                next_state = SYNC;
            end
        endcase
    end

    // The first byte of a line arrives in the same cycle lv_a rises, so it sees a fresh phase/count.
    assign eff_phase   = line_start ? 2'd0 : phase;
    assign eff_count   = line_start ? 12'd0 : byte_cnt;
    assign lines_final = end_line ? sat_inc(line_cnt) : line_cnt;

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            phase    <= 2'd0;
            byte_cnt <= 12'd0;
            x_cnt    <= 12'd0;
            y_cnt    <= 12'd0;
            line_cnt <= 12'd0;
            r_byte   <= 8'd0;
            g_byte   <= 8'd0;
        end else begin
            if (frame_start) begin
                y_cnt    <= 12'd0;
                line_cnt <= 12'd0;
            end
            if (line_start) begin
                x_cnt <= 12'd0;
            end
            if (capture) begin
                byte_cnt <= sat_inc(eff_count);
                case (eff_phase)
                    2'd0: begin
                        r_byte <= data;
                        phase  <= 2'd1;
                    end
                    2'd1: begin
                        g_byte <= data;
                        phase  <= 2'd2;
                    end
                    default: begin
                        x_cnt <= x_cnt + 12'd1;
                        phase <= 2'd0;
                    end
                endcase
            end
            if (end_line) begin
                y_cnt    <= sat_inc(y_cnt);
                line_cnt <= sat_inc(line_cnt);
                phase    <= 2'd0;
            end
        end
    end

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_rgb     <= 24'd0;
            pix_x       <= 12'd0;
            pix_y       <= 12'd0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            frame_done  <= 1'b0;
            line_bytes  <= 12'd0;
            frame_lines <= 12'd0;
        end else begin
            pix_valid  <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            if (capture && (eff_phase == 2'd2)) begin
                pix_valid <= 1'b1;
                pix_rgb   <= {r_byte, g_byte, data};
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                sof       <= (x_cnt == 12'd0) && (y_cnt == 12'd0);
            end
            if (end_line) begin
                line_bytes <= byte_cnt;
                eol        <= 1'b1;
            end
            if (end_frame) begin
                frame_lines <= lines_final;
                frame_done  <= 1'b1;
            end
        end
    end

    assign set_partial = end_line && (phase != 2'd0);
    assign set_width   = end_line && (byte_cnt != BPL_W);
    assign set_height  = end_frame && (lines_final != LPF_W);

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            err_partial <= 1'b0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
        end else begin
            err_partial <= set_partial | (err_partial & ~err_clr);
            err_width   <= set_width   | (err_width   & ~err_clr);
            err_height  <= set_height  | (err_height  & ~err_clr);
        end
    end

endmodule

// File: tb/tb_video_stream_rx.sv
// Bench for video_stream_rx: two instances (no lv delay / one-cycle lv delay) driven with
// random and fixed frames, compared against a frame-level model of pixels, counts and flags.
module tb_video_stream_rx;

    localparam int BPL0 = 6;
    localparam int LPF0 = 2;
    localparam int BPL1 = 6;
    localparam int LPF1 = 170;

    typedef struct {
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
    } pix_t;

    logic        pixclk = 1'b0;
    logic        rst_i [2];
    logic        fv_i [2];
    logic        lv_i [2];
    logic        clr_i [2];
    logic [7:0]  data_i [2];
    logic        pix_valid_o [2];
    logic [23:0] pix_rgb_o [2];
    logic [11:0] pix_x_o [2];
    logic [11:0] pix_y_o [2];
    logic        sof_o [2];
    logic        eol_o [2];
    logic        frame_done_o [2];
    logic [11:0] line_bytes_o [2];
    logic [11:0] frame_lines_o [2];
    logic        err_partial_o [2];
    logic        err_width_o [2];
    logic        err_height_o [2];

    int   n_checks = 0;
    int   n_pass   = 0;
    pix_t q0[$];
    pix_t q1[$];
    int   bpl [2] = '{BPL0, BPL1};
    int   lpf [2] = '{LPF0, LPF1};
    int   exp_line_bytes [2];
    int   exp_frame_lines [2];
    int   exp_eol [2];
    int   exp_fd [2];
    int   eol_cnt [2];
    int   fd_cnt [2];
    bit   exp_partial [2];
    bit   exp_width [2];
    bit   exp_height [2];
    logic [7:0] pend1 = 8'd0;

    always #5 pixclk = ~pixclk;

    video_stream_rx #(.BYTES_PER_LINE(BPL0), .LINES_PER_FRAME(LPF0), .LV_DELAY(0)) dut0 (
        .pixclk(pixclk), .rst(rst_i[0]), .fv(fv_i[0]), .lv(lv_i[0]), .data(data_i[0]),
        .err_clr(clr_i[0]), .pix_valid(pix_valid_o[0]), .pix_rgb(pix_rgb_o[0]),
        .pix_x(pix_x_o[0]), .pix_y(pix_y_o[0]), .sof(sof_o[0]), .eol(eol_o[0]),
        .frame_done(frame_done_o[0]), .line_bytes(line_bytes_o[0]),
        .frame_lines(frame_lines_o[0]), .err_partial(err_partial_o[0]),
        .err_width(err_width_o[0]), .err_height(err_height_o[0])
    );

    video_stream_rx #(.BYTES_PER_LINE(BPL1), .LINES_PER_FRAME(LPF1), .LV_DELAY(1)) dut1 (
        .pixclk(pixclk), .rst(rst_i[1]), .fv(fv_i[1]), .lv(lv_i[1]), .data(data_i[1]),
        .err_clr(clr_i[1]), .pix_valid(pix_valid_o[1]), .pix_rgb(pix_rgb_o[1]),
        .pix_x(pix_x_o[1]), .pix_y(pix_y_o[1]), .sof(sof_o[1]), .eol(eol_o[1]),
        .frame_done(frame_done_o[1]), .line_bytes(line_bytes_o[1]),
        .frame_lines(frame_lines_o[1]), .err_partial(err_partial_o[1]),
        .err_width(err_width_o[1]), .err_height(err_height_o[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Instance 1 mimics the pattern generator: its data lags lv/fv by one clock.
    task automatic applyStimulus(input int w, input logic f, input logic l, input logic [7:0] d);
        if (w == 0) begin
            fv_i[0]   = f;
            lv_i[0]   = l;
            data_i[0] = d;
        end else begin
            fv_i[1]   = f;
            lv_i[1]   = l;
            data_i[1] = pend1;
            pend1     = d;
        end
        @(posedge pixclk);
        #1;
    endtask

    function automatic logic [7:0] pattern_byte(input int l, input int k);
        logic [23:0] col;
        col = (l < 80) ? 24'h0000F0 : ((l < 160) ? 24'h00F000 : 24'hF00000);
        case (k % 3)
            0:       return col[23:16];
            1:       return col[15:8];
            default: return col[7:0];
        endcase
    endfunction

    task automatic model_line(input int w, input int y, input logic [7:0] b[$]);
        pix_t p;
        for (int k = 0; k < b.size() / 3; k++) begin
            p.rgb = {b[3*k], b[3*k+1], b[3*k+2]};
            p.x   = 12'(k);
            p.y   = 12'(y);
            p.sof = (k == 0) && (y == 0);
            if (w == 0) q0.push_back(p);
            else        q1.push_back(p);
        end
        exp_line_bytes[w] = b.size();
        if (b.size() % 3 != 0) exp_partial[w] = 1'b1;
        if (b.size() != bpl[w]) exp_width[w] = 1'b1;
        exp_eol[w]++;
    endtask

    task automatic model_frame_end(input int w, input int nlines, input bit clr);
        if (clr) begin
            exp_partial[w] = 1'b0;
            exp_width[w]   = 1'b0;
            exp_height[w]  = 1'b0;
        end
        exp_frame_lines[w] = nlines;
        if (nlines != lpf[w]) exp_height[w] = 1'b1;
        exp_fd[w]++;
    endtask

    task automatic model_reset(input int w);
        exp_line_bytes[w]  = 0;
        exp_frame_lines[w] = 0;
        exp_partial[w]     = 1'b0;
        exp_width[w]       = 1'b0;
        exp_height[w]      = 1'b0;
    endtask

    task automatic check_pixel(input int w);
        pix_t p;
        bit   empty;
        empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checkOutput($sformatf("d%0d_pix_unexpected", w), 32'd1, 32'd0);
        end else begin
            p = (w == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("d%0d_pix_rgb", w), 32'(pix_rgb_o[w]), 32'(p.rgb));
            checkOutput($sformatf("d%0d_pix_x", w), 32'(pix_x_o[w]), 32'(p.x));
            checkOutput($sformatf("d%0d_pix_y", w), 32'(pix_y_o[w]), 32'(p.y));
            checkOutput($sformatf("d%0d_sof", w), 32'(sof_o[w]), 32'(p.sof));
        end
    endtask

    always @(negedge pixclk) begin
        for (int w = 0; w < 2; w++) begin
            if (eol_o[w] === 1'b1) eol_cnt[w]++;
            if (frame_done_o[w] === 1'b1) fd_cnt[w]++;
            if (pix_valid_o[w] === 1'b1) check_pixel(w);
        end
    end

    task automatic check_frame(input int w);
        checkOutput($sformatf("d%0d_line_bytes", w), 32'(line_bytes_o[w]), 32'(exp_line_bytes[w]));
        checkOutput($sformatf("d%0d_frame_lines", w), 32'(frame_lines_o[w]), 32'(exp_frame_lines[w]));
        checkOutput($sformatf("d%0d_err_partial", w), 32'(err_partial_o[w]), 32'(exp_partial[w]));
        checkOutput($sformatf("d%0d_err_width", w), 32'(err_width_o[w]), 32'(exp_width[w]));
        checkOutput($sformatf("d%0d_err_height", w), 32'(err_height_o[w]), 32'(exp_height[w]));
        checkOutput($sformatf("d%0d_eol_count", w), 32'(eol_cnt[w]), 32'(exp_eol[w]));
        checkOutput($sformatf("d%0d_frame_done_count", w), 32'(fd_cnt[w]), 32'(exp_fd[w]));
        checkOutput($sformatf("d%0d_pix_left", w), 32'((w == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    task automatic check_reset_state(input int w);
        checkOutput($sformatf("d%0d_rst_pix_valid", w), 32'(pix_valid_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_pix_rgb", w), 32'(pix_rgb_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_eol", w), 32'(eol_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_frame_done", w), 32'(frame_done_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_line_bytes", w), 32'(line_bytes_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_frame_lines", w), 32'(frame_lines_o[w]), 32'd0);
        checkOutput($sformatf("d%0d_rst_errs", w),
                    32'({err_partial_o[w], err_width_o[w], err_height_o[w]}), 32'd0);
    endtask

    // mode 0: random bytes, 1: repeating 11..66, 2: colour bands by line index
    task automatic send_frame(input int w, input int lens[$], input int mode,
                              input bit clr_at_end, input bit cut_last);
        logic [7:0] b[$];
        int nl;
        nl = lens.size();
        repeat ($urandom_range(1, 3)) applyStimulus(w, 1'b1, 1'b0, 8'd0);
        for (int l = 0; l < nl; l++) begin
            b.delete();
            for (int k = 0; k < lens[l]; k++) begin
                if (mode == 1)      b.push_back(8'(17 * ((k % 6) + 1)));
                else if (mode == 2) b.push_back(pattern_byte(l, k));
                else                b.push_back(8'($urandom_range(0, 255)));
            end
            model_line(w, l, b);
            foreach (b[k]) applyStimulus(w, 1'b1, 1'b1, b[k]);
            if (!(cut_last && (l == nl - 1))) begin
                repeat ($urandom_range(1, 3)) applyStimulus(w, 1'b1, 1'b0, 8'd0);
            end
        end
        clr_i[w] = clr_at_end;
        applyStimulus(w, 1'b0, cut_last, 8'd0);
        clr_i[w] = 1'b0;
        model_frame_end(w, nl, clr_at_end);
        if (cut_last) begin
            checkOutput("cut_eol_after_fall", 32'(eol_o[w]), 32'd1);
            checkOutput("cut_frame_done_after_fall", 32'(frame_done_o[w]), 32'd1);
            applyStimulus(w, 1'b0, 1'b0, 8'd0);
            checkOutput("cut_eol_single_pulse", 32'(eol_o[w]), 32'd0);
            checkOutput("cut_frame_done_single_pulse", 32'(frame_done_o[w]), 32'd0);
        end
        repeat (3) applyStimulus(w, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic pulse_clr(input int w);
        clr_i[w] = 1'b1;
        applyStimulus(w, 1'b0, 1'b0, 8'd0);
        clr_i[w] = 1'b0;
        exp_partial[w] = 1'b0;
        exp_width[w]   = 1'b0;
        exp_height[w]  = 1'b0;
        checkOutput($sformatf("d%0d_errs_after_clr", w),
                    32'({err_partial_o[w], err_width_o[w], err_height_o[w]}), 32'd0);
    endtask

    task automatic stream_uncaptured(input int w, input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            applyStimulus(w, 1'b1, ((c % 8) < 6), 8'($urandom_range(0, 255)));
        end
    endtask

    // Reset asserted at an idle moment, then released while a frame is already running.
    task automatic reset_into_running_frame(input int w);
        int lens[$];
        rst_i[w] = 1'b1;
        #1;
        check_reset_state(w);
        model_reset(w);
        stream_uncaptured(w, 8);
        rst_i[w] = 1'b0;
        stream_uncaptured(w, 24);
        repeat (3) applyStimulus(w, 1'b0, 1'b0, 8'd0);
        check_frame(w);
        lens.delete();
        repeat (lpf[w] < 4 ? lpf[w] : 3) lens.push_back(bpl[w]);
        send_frame(w, lens, 0, 1'b0, 1'b0);
        check_frame(w);
    endtask

    initial begin
        int lens[$];
        int n;
        for (int w = 0; w < 2; w++) begin
            rst_i[w]  = 1'b1;
            fv_i[w]   = 1'b0;
            lv_i[w]   = 1'b0;
            clr_i[w]  = 1'b0;
            data_i[w] = 8'd0;
            model_reset(w);
            exp_eol[w] = 0;
            exp_fd[w]  = 0;
            eol_cnt[w] = 0;
            fd_cnt[w]  = 0;
        end
        repeat (3) @(posedge pixclk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        repeat (2) applyStimulus(0, 1'b0, 1'b0, 8'd0);

        // Fixed bytes 11..66 over two good lines
        lens.delete(); lens.push_back(6); lens.push_back(6);
        send_frame(0, lens, 1, 1'b0, 1'b0);
        check_frame(0);
        checkOutput("t1_frame_lines", 32'(frame_lines_o[0]), 32'd2);
        checkOutput("t1_last_rgb", 32'(pix_rgb_o[0]), 32'h445566);

        // A 7-byte line: partial and width errors that persist through a good frame
        lens.delete(); lens.push_back(6); lens.push_back(7);
        send_frame(0, lens, 0, 1'b0, 1'b0);
        check_frame(0);
        checkOutput("t2_line_bytes", 32'(line_bytes_o[0]), 32'd7);
        checkOutput("t2_err_partial", 32'(err_partial_o[0]), 32'd1);
        checkOutput("t2_err_width", 32'(err_width_o[0]), 32'd1);
        lens.delete(); lens.push_back(6); lens.push_back(6);
        send_frame(0, lens, 0, 1'b0, 1'b0);
        check_frame(0);
        pulse_clr(0);

        // Three-line frames: height error, and clear colliding with a new height error
        lens.delete(); repeat (3) lens.push_back(6);
        send_frame(0, lens, 0, 1'b0, 1'b0);
        check_frame(0);
        checkOutput("t3_frame_lines", 32'(frame_lines_o[0]), 32'd3);
        send_frame(0, lens, 0, 1'b1, 1'b0);
        check_frame(0);
        checkOutput("t3_height_set_wins", 32'(err_height_o[0]), 32'd1);
        lens.delete(); lens.push_back(6); lens.push_back(6);
        send_frame(0, lens, 0, 1'b1, 1'b0);
        check_frame(0);
        checkOutput("t3_height_cleared", 32'(err_height_o[0]), 32'd0);

        // fv falls while lv is still high after 3 bytes
        lens.delete(); lens.push_back(6); lens.push_back(3);
        send_frame(0, lens, 0, 1'b0, 1'b1);
        check_frame(0);
        checkOutput("t6_line_bytes", 32'(line_bytes_o[0]), 32'd3);
        checkOutput("t6_no_partial", 32'(err_partial_o[0]), 32'd0);
        lens.delete(); lens.push_back(6); lens.push_back(6);
        send_frame(0, lens, 0, 1'b0, 1'b0);
        check_frame(0);
        pulse_clr(0);

        reset_into_running_frame(0);

        for (int f = 0; f < 6; f++) begin
            lens.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) lens.push_back($urandom_range(3, 9));
            send_frame(0, lens, 0, 1'b0, 1'b0);
            check_frame(0);
        end

        // Delayed-lv instance: colour-band frame of nominal size
        repeat (2) applyStimulus(1, 1'b0, 1'b0, 8'd0);
        lens.delete(); repeat (LPF1) lens.push_back(BPL1);
        send_frame(1, lens, 2, 1'b0, 1'b0);
        check_frame(1);
        checkOutput("t5_err_width", 32'(err_width_o[1]), 32'd0);
        checkOutput("t5_err_height", 32'(err_height_o[1]), 32'd0);
        checkOutput("t5_frame_lines", 32'(frame_lines_o[1]), 32'(LPF1));

        reset_into_running_frame(1);

        for (int f = 0; f < 4; f++) begin
            lens.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) lens.push_back($urandom_range(3, 9));
            send_frame(1, lens, 0, 1'b0, 1'b0);
            check_frame(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
